// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Encodes the MADD op and the ACC state even when HILO_MADD_EN is undefined.
package hilo_muldiv_ctrl_pkg;

  localparam int unsigned HILO_DW         = 32;
  localparam int unsigned HILO_DIV_CYCLES = HILO_DW;

  typedef enum logic [2:0] {
    HILO_OP_NONE  = 3'd0,
    HILO_OP_MULT  = 3'd1,
    HILO_OP_MULTU = 3'd2,
    HILO_OP_DIV   = 3'd3,
    HILO_OP_DIVU  = 3'd4,
    HILO_OP_MTHI  = 3'd5,
    HILO_OP_MTLO  = 3'd6,
    HILO_OP_MADD  = 3'd7
  } hilo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DONE = 3'd3,
    ST_ACC  = 3'd4
  } hilo_state_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle, DW cycles.
module hilo_muldiv_ctrl_div_iter
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DW = HILO_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          clear,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done_c,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  logic [CW-1:0] cnt;
  logic [DW-1:0] dvs;
  logic [DW:0]   shifted;
  logic [DW:0]   diff;

  // Trial subtraction of the divisor from the partial remainder shifted left by one.
  always_comb begin
    shifted = {remainder, quotient[DW-1]};
    diff    = shifted - {1'b0, dvs};
  end

  assign done_c = busy && (cnt == CW'(DW - 1));

  // Iteration counter plus quotient/remainder registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= '0;
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      if (!diff[DW]) begin
        remainder <= diff[DW-1:0];
        quotient  <= {quotient[DW-2:0], 1'b1};
      end else begin
        remainder <= shifted[DW-1:0];
        quotient  <= {quotient[DW-2:0], 1'b0};
      end
      cnt <= done_c ? '0 : cnt + CW'(1);
      if (done_c) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: MT*, multi-cycle multiply, iterative divide, flush abort.
// Optional build macro HILO_MADD_EN adds op 7 (MADD) with an ACC state after MUL.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DW = HILO_DW
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [DW-1:0]   src_a,
  input  logic [DW-1:0]   src_b,
  input  logic            cancel,
  input  logic [2*DW-1:0] hilo_cur,
  output logic            stall_o,
  output logic [DW-1:0]   hi,
  output logic            hi_wen,
  output logic [DW-1:0]   lo,
  output logic            lo_wen,
  output logic            busy
);

  localparam int unsigned PW = 2 * DW;

  hilo_state_e state, state_next;
  hilo_op_e    op_in;

  logic          op_ok;
  logic          accept_c;
  logic          mul_start_c;
  logic          div_start_c;
  logic          div_signed_c;
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          is_div_q;
  logic          mul_signed_q;
  logic          q_neg_q;
  logic          r_neg_q;
  logic [PW-1:0] prod_q;
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [DW-1:0] div_lo;
  logic [DW-1:0] div_hi;

  logic          div_busy;
  logic          div_done_c;
  logic [DW-1:0] div_quo;
  logic [DW-1:0] div_rem;

`ifdef HILO_MADD_EN
  logic madd_q;
`else
  logic unused_hilo_cur;
  assign unused_hilo_cur = ^hilo_cur;
`endif

  assign op_in        = hilo_op_e'(op);
  assign div_signed_c = (op_in == HILO_OP_DIV);
  assign accept_c     = resetn && (state == ST_IDLE) && op_valid && !cancel && op_ok;
  assign busy         = (state != ST_IDLE);

  // Ops this build accepts; MADD only when the accumulate feature is present.
  always_comb begin
    op_ok = 1'b0;
    case (op_in)
      HILO_OP_MULT, HILO_OP_MULTU, HILO_OP_DIV,
      HILO_OP_DIVU, HILO_OP_MTHI, HILO_OP_MTLO: op_ok = 1'b1;
`ifdef HILO_MADD_EN
      HILO_OP_MADD:                             op_ok = 1'b1;
`endif
      default:                                  op_ok = 1'b0;
    endcase
  end

  // Operand magnitudes for the unsigned divider core.
  always_comb begin
    a_mag = (div_signed_c && src_a[DW-1]) ? DW'(0) - src_a : src_a;
    b_mag = (div_signed_c && src_b[DW-1]) ? DW'(0) - src_b : src_b;
  end

  // Multiplier operands widened to full product width (sign- or zero-extended).
  always_comb begin
    a_ext = mul_signed_q ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
    b_ext = mul_signed_q ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
  end

  // Divide result with sign correction; a zero divisor returns all-ones / dividend.
  always_comb begin
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end else begin
      div_lo = q_neg_q ? DW'(0) - div_quo : div_quo;
      div_hi = r_neg_q ? DW'(0) - div_rem : div_rem;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stall and HI/LO write strobes; cancel overrides everything.
  always_comb begin
    state_next  = state;
    stall_o     = 1'b0;
    hi_wen      = 1'b0;
    lo_wen      = 1'b0;
    hi          = hi_q;
    lo          = lo_q;
    mul_start_c = 1'b0;
    div_start_c = 1'b0;
    if (cancel) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            case (op_in)
              HILO_OP_MTHI: begin
                hi     = src_a;
                hi_wen = 1'b1;
              end
              HILO_OP_MTLO: begin
                lo     = src_a;
                lo_wen = 1'b1;
              end
              HILO_OP_DIV, HILO_OP_DIVU: begin
                stall_o     = 1'b1;
                div_start_c = 1'b1;
                state_next  = ST_DIV;
              end
              default: begin
                stall_o     = 1'b1;
                mul_start_c = 1'b1;
                state_next  = ST_MUL;
              end
            endcase
          end
        end
        ST_MUL: begin
          stall_o = 1'b1;
`ifdef HILO_MADD_EN
          state_next = madd_q ? ST_ACC : ST_DONE;
`else
          state_next = ST_DONE;
`endif
        end
`ifdef HILO_MADD_EN
        ST_ACC: begin
          stall_o    = 1'b1;
          state_next = ST_DONE;
        end
`endif
        ST_DIV: begin
          stall_o = 1'b1;
          if (div_done_c || !div_busy) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          hi_wen = 1'b1;
          lo_wen = 1'b1;
          if (is_div_q) begin
            hi = div_hi;
            lo = div_lo;
          end else begin
            {hi, lo} = prod_q;
          end
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Operand capture, product/accumulate register and HI/LO hold registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q          <= '0;
      b_q          <= '0;
      is_div_q     <= 1'b0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      prod_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
`ifdef HILO_MADD_EN
      madd_q       <= 1'b0;
`endif
    end else begin
      if (mul_start_c || div_start_c) begin
        a_q          <= src_a;
        b_q          <= src_b;
        is_div_q     <= div_start_c;
        mul_signed_q <= (op_in != HILO_OP_MULTU);
        q_neg_q      <= div_signed_c && (src_a[DW-1] ^ src_b[DW-1]);
        r_neg_q      <= div_signed_c && src_a[DW-1];
`ifdef HILO_MADD_EN
        madd_q       <= (op_in == HILO_OP_MADD);
`endif
      end
      if (state == ST_MUL) begin
        prod_q <= a_ext * b_ext;
      end
`ifdef HILO_MADD_EN
      if (state == ST_ACC) begin
        prod_q <= prod_q + hilo_cur;
      end
`endif
      if (hi_wen) begin
        hi_q <= hi;
      end
      if (lo_wen) begin
        lo_q <= lo;
      end
    end
  end

  hilo_muldiv_ctrl_div_iter #(
    .DW(DW)
  ) u_div_iter (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start_c),
    .clear    (cancel),
    .dividend (a_mag),
    .divisor  (b_mag),
    .busy     (div_busy),
    .done_c   (div_done_c),
    .quotient (div_quo),
    .remainder(div_rem)
  );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus random ops vs. an arithmetic model.
module tb_hilo_muldiv_ctrl;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic [63:0] hilo_cur;
  logic        stall_o;
  logic [31:0] hi;
  logic        hi_wen;
  logic [31:0] lo;
  logic        lo_wen;
  logic        busy;

  logic [31:0] hi_m;
  logic [31:0] lo_m;
  int          n_checks;
  int          n_errors;

  assign hilo_cur = {hi_m, lo_m};

  hilo_muldiv_ctrl dut (
    .clk     (clk),
    .resetn  (resetn),
    .op_valid(op_valid),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .cancel  (cancel),
    .hilo_cur(hilo_cur),
    .stall_o (stall_o),
    .hi      (hi),
    .hi_wen  (hi_wen),
    .lo      (lo),
    .lo_wen  (lo_wen),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural result of one op: write latency, expected HI/LO and which halves are written.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output logic [31:0] eh, output logic [31:0] el,
                                output logic [1:0] ew);
    logic [63:0] p;
    int sa, sb;
    eh = hi_m;
    el = lo_m;
    ew = 2'b11;
    lat = 0;
    case (o)
      3'd1: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        {eh, el} = p;
        lat = 2;
      end
      3'd2: begin
        p = {32'd0, a} * {32'd0, b};
        {eh, el} = p;
        lat = 2;
      end
      3'd3: begin
        lat = 33;
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else begin
          sa = $signed(a);
          sb = $signed(b);
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end
      end
      3'd4: begin
        lat = 33;
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
      3'd5: begin
        eh = a;
        ew = 2'b10;
      end
      3'd6: begin
        el = a;
        ew = 2'b01;
      end
      default: begin
`ifdef HILO_MADD_EN
        if (o == 3'd7) begin
          p = {hi_m, lo_m} + 64'(longint'($signed(a)) * longint'($signed(b)));
          {eh, el} = p;
          lat = 3;
        end else begin
          ew = 2'b00;
        end
`else
        ew = 2'b00;
`endif
      end
    endcase
  endfunction

  // Issue one op at posedge+1 and follow it cycle by cycle until it retires.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] eh, el;
    logic [1:0] ew;
    model(o, a, b, lat, eh, el, ew);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    check("accept_busy", 64'(busy), 64'd0);
    if (lat == 0) begin
      check("mt_stall", 64'(stall_o), 64'd0);
      check("mt_wen", 64'({hi_wen, lo_wen}), 64'(ew));
      if (ew[1]) check("mt_hi", 64'(hi), 64'(eh));
      if (ew[0]) check("mt_lo", 64'(lo), 64'(el));
    end else begin
      check("accept_stall", 64'(stall_o), 64'd1);
      check("accept_wen", 64'({hi_wen, lo_wen}), 64'd0);
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk);
        #1;
        src_a = $urandom;
        src_b = $urandom;
        @(negedge clk);
        check("run_busy", 64'(busy), 64'd1);
        if (k < lat) begin
          check("run_stall", 64'(stall_o), 64'd1);
          check("run_wen", 64'({hi_wen, lo_wen}), 64'd0);
        end else begin
          check("done_stall", 64'(stall_o), 64'd0);
          check("done_wen", 64'({hi_wen, lo_wen}), 64'd3);
          check("done_hi", 64'(hi), 64'(eh));
          check("done_lo", 64'(lo), 64'(el));
        end
      end
    end
    hi_m = eh;
    lo_m = el;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op = 3'd0;
    @(negedge clk);
    check("after_busy", 64'(busy), 64'd0);
    check("after_stall", 64'(stall_o), 64'd0);
    check("after_wen", 64'({hi_wen, lo_wen}), 64'd0);
    check("hold_hi", 64'(hi), 64'(hi_m));
    check("hold_lo", 64'(lo), 64'(lo_m));
    @(posedge clk);
    #1;
  endtask

  // Start a multi-cycle op and flush it in cycle 'at' (at = latency hits the DONE cycle).
  task automatic run_cancel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int at);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    check("cx_accept_stall", 64'(stall_o), 64'd1);
    for (int k = 1; k <= at; k++) begin
      @(posedge clk);
      #1;
      if (k == at) cancel = 1'b1;
      @(negedge clk);
      if (k < at) begin
        check("cx_stall", 64'(stall_o), 64'd1);
      end else begin
        check("cx_stall_drop", 64'(stall_o), 64'd0);
        check("cx_no_wen", 64'({hi_wen, lo_wen}), 64'd0);
        check("cx_hold_hi", 64'(hi), 64'(hi_m));
        check("cx_hold_lo", 64'(lo), 64'(lo_m));
      end
    end
    @(posedge clk);
    #1;
    cancel = 1'b0;
    op_valid = 1'b0;
    op = 3'd0;
  endtask

  // Flush arriving in the same cycle as the op would be accepted.
  task automatic cancel_accept(input logic [2:0] o, input logic [31:0] a);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = 32'd3;
    cancel = 1'b1;
    @(negedge clk);
    check("ca_stall", 64'(stall_o), 64'd0);
    check("ca_wen", 64'({hi_wen, lo_wen}), 64'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    op_valid = 1'b0;
    op = 3'd0;
    @(negedge clk);
    check("ca_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    int r;
    n_checks = 0;
    n_errors = 0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    op_valid = 1'b0;
    op = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    cancel = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_wen", 64'({hi_wen, lo_wen}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;

    do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    do_op(3'd4, 32'd100, 32'd7);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd4, 32'd5, 32'd0);
    do_op(3'd3, 32'hFFFF_FFF0, 32'd0);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd6, 32'h0000_1234, 32'd0);
    do_op(3'd5, 32'h0BAD_F00D, 32'd0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd7, 32'd11, 32'd13);

    // op_valid low: nothing may be accepted
    op = 3'd1;
    src_a = 32'd9;
    src_b = 32'd9;
    @(negedge clk);
    check("novalid_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    op = 3'd0;
    @(negedge clk);
    check("novalid_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    run_cancel(3'd3, 32'd1000, 32'd7, 10);
    do_op(3'd2, 32'd2, 32'd3);
    run_cancel(3'd4, 32'd77, 32'd5, 33);
    run_cancel(3'd1, 32'd4, 32'd5, 1);
    run_cancel(3'd2, 32'd4, 32'd5, 2);
    cancel_accept(3'd3, 32'd50);
    cancel_accept(3'd5, 32'h5555_AAAA);
    cancel_accept(3'd6, 32'hAAAA_5555);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(1, 6));
      a = rnd_val();
      b = rnd_val();
      r = $urandom_range(0, 9);
      if (r == 0 && o <= 3'd4) begin
        run_cancel(o, a, b, (o <= 3'd2) ? $urandom_range(1, 2) : $urandom_range(1, 33));
      end else if (r == 1) begin
        cancel_accept(o, a);
      end else begin
        do_op(o, a, b);
      end
    end

    // Asynchronous reset in the middle of a divide
    do_op(3'd5, 32'hDEAD_BEEF, 32'd0);
    op_valid = 1'b1;
    op = 3'd3;
    src_a = 32'd1000;
    src_b = 32'd3;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    op_valid = 1'b0;
    op = 3'd0;
    #1;
    check("mrst_hi", 64'(hi), 64'd0);
    check("mrst_lo", 64'(lo), 64'd0);
    check("mrst_wen", 64'({hi_wen, lo_wen}), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_stall", 64'(stall_o), 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({hi_wen, lo_wen, stall_o, busy}), 64'd0);
      @(posedge clk);
      #1;
    end
    do_op(3'd4, 32'd9, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
